// File: rtl/ahb_pkg.sv
// Shared AHB slave-side types: response codes, slave FSM states and lane helpers.
package ahb_pkg;

  localparam int ADDR_WIDTH_DEF = 32;
  localparam int DATA_WIDTH_DEF = 32;

  function automatic int byte_lanes(input int data_width);
    return data_width / 8;
  endfunction

  localparam int BYTE_LANES = byte_lanes(DATA_WIDTH_DEF);

  typedef enum logic [1:0] {
    OKAY  = 2'b00,
    ERROR = 2'b01
  } resp_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ERR1,
    ERR2
  } slave_state_e;

endpackage

// File: rtl/ahb_sram_array.sv
// Word-wide register array: synchronous write port, combinational read port,
// optionally cleared by the asynchronous reset.
module ahb_sram_array #(
  parameter int DEPTH      = 256,
  parameter int DATA_WIDTH = 32,
  parameter int INIT_ZERO  = 1,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  generate
    if (INIT_ZERO != 0) begin : g_reset
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
          end
        end else if (we) begin
          mem[waddr] <= wdata;
        end
      end
    end else begin : g_noreset
      always_ff @(posedge clk) begin
        if (we) begin
          mem[waddr] <= wdata;
        end
      end
    end
  endgenerate

  assign rdata = mem[raddr];

endmodule

// File: rtl/ahb_sram_slave_core.sv
// AHB SRAM endpoint: address check, wait-state counter and two-cycle ERROR
// response around a register array. Owns all data-phase timing (ready/resp).
module ahb_sram_slave_core
  import ahb_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int                    DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int                    DEPTH       = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_STATES = 0,
  parameter int                    INIT_ZERO   = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  write_en,
  input  logic                  read_en,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  ready,
  output logic [1:0]            resp
);

  localparam int LANES  = byte_lanes(DATA_WIDTH);
  localparam int OFF_W  = $clog2(LANES);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int WORD_W = ADDR_WIDTH - OFF_W;
  localparam logic [WORD_W-1:0] BASE_WORD = BASE_ADDR[ADDR_WIDTH-1:OFF_W];
  localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  slave_state_e          state;
  slave_state_e          next_state;
  logic [3:0]            cnt;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      idx_q;
  logic [IDX_W-1:0]      raddr;
  logic                  read_q;
  logic [WORD_W-1:0]     word_addr;
  logic [WORD_W-1:0]     word_off;
  logic                  in_range;
  logic                  misaligned;
  logic                  illegal;
  logic                  request;
  logic                  accept;
  logic                  mem_we;
  logic                  rd_done;
  logic                  ready_c;
  resp_e                 resp_c;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [DATA_WIDTH-1:0] rdata_q;

  // Range check on word addresses (BASE_ADDR is word aligned): the word
  // offset must not underflow and must fit in IDX_W bits.
  assign word_addr  = addr[ADDR_WIDTH-1:OFF_W];
  assign word_off   = word_addr - BASE_WORD;
  assign in_range   = (word_addr >= BASE_WORD) && (word_off[WORD_W-1:IDX_W] == '0);
  assign misaligned = |addr[OFF_W-1:0];
  assign illegal    = !in_range || misaligned || (write_en && read_en);
  assign idx        = word_off[IDX_W-1:0];

  assign request = (write_en || read_en) && (state == IDLE);
  assign accept  = request && !illegal;
  assign mem_we  = accept && write_en;
  assign raddr   = (state == IDLE) ? idx : idx_q;

  always_comb begin
    next_state = state;
    ready_c    = 1'b1;
    resp_c     = OKAY;
    rd_done    = 1'b0;
    case (state)
      IDLE: begin
        if (request) begin
          // An illegal request is the ERR1 cycle itself; only ERR2 is registered.
          if (illegal) begin
            ready_c    = 1'b0;
            resp_c     = ERROR;
            next_state = ERR2;
          end else if (WAIT_STATES == 0) begin
            rd_done = read_en;
          end else begin
            ready_c    = 1'b0;
            next_state = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt != 4'd0) begin
          ready_c = 1'b0;
        end else begin
          rd_done    = read_q;
          next_state = IDLE;
        end
      end
      ERR1: begin
        ready_c    = 1'b0;
        resp_c     = ERROR;
        next_state = ERR2;
      end
      ERR2: begin
        resp_c     = ERROR;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      idx_q   <= '0;
      read_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        idx_q  <= idx;
        read_q <= read_en;
        cnt    <= CNT_LOAD;
      end else if ((state == WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (rd_done) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  ahb_sram_array #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .INIT_ZERO  (INIT_ZERO),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk    (clk),
    .resetn (resetn),
    .we     (mem_we),
    .waddr  (idx),
    .wdata  (write_data),
    .raddr  (raddr),
    .rdata  (mem_rdata)
  );

  assign ready     = ready_c;
  assign resp      = resp_c;
  assign read_data = rd_done ? mem_rdata : rdata_q;

endmodule

// File: tb/tb_ahb_sram_slave_core.sv
// Directed bench: zero-wait table on one instance, hand sequences for wait
// states, error responses and asynchronous reset on instances with 3 and 5 waits.
module tb_ahb_sram_slave_core;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        write_en;
  logic        read_en;

  logic [31:0] rd0, rd3, rd5;
  logic        rdy0, rdy3, rdy5;
  logic [1:0]  rsp0, rsp3, rsp5;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ahb_sram_slave_core #(.DEPTH(256), .BASE_ADDR(32'h0), .WAIT_STATES(0), .INIT_ZERO(1)) u0 (
    .clk(clk), .resetn(resetn), .addr(addr), .write_data(write_data),
    .write_en(write_en), .read_en(read_en), .read_data(rd0), .ready(rdy0), .resp(rsp0));

  ahb_sram_slave_core #(.DEPTH(256), .BASE_ADDR(32'h0), .WAIT_STATES(3), .INIT_ZERO(1)) u3 (
    .clk(clk), .resetn(resetn), .addr(addr), .write_data(write_data),
    .write_en(write_en), .read_en(read_en), .read_data(rd3), .ready(rdy3), .resp(rsp3));

  ahb_sram_slave_core #(.DEPTH(256), .BASE_ADDR(32'h0), .WAIT_STATES(5), .INIT_ZERO(1)) u5 (
    .clk(clk), .resetn(resetn), .addr(addr), .write_data(write_data),
    .write_en(write_en), .read_en(read_en), .read_data(rd5), .ready(rdy5), .resp(rsp5));

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] a;
    logic [31:0] wd;
    logic        exp_rdy;
    logic [1:0]  exp_rsp;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [18];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one request cycle just after the rising edge, return at the falling edge.
  task automatic applyStimulus(input logic we, input logic re, input logic [31:0] a, input logic [31:0] wd);
    @(posedge clk);
    #1;
    write_en   = we;
    read_en    = re;
    addr       = a;
    write_data = wd;
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 32'h010, 32'hDEADBEEF, 1'b1, 2'b00, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, 32'h010, 32'h0,        1'b1, 2'b00, 1'b1, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 1'b0, 32'h014, 32'h12345678, 1'b1, 2'b00, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 32'h000, 32'hA5A5A5A5, 1'b1, 2'b00, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 1'b1, 32'h014, 32'h0,        1'b1, 2'b00, 1'b1, 32'h12345678};
    vecs[5]  = '{1'b0, 1'b1, 32'h000, 32'h0,        1'b1, 2'b00, 1'b1, 32'hA5A5A5A5};
    vecs[6]  = '{1'b0, 1'b0, 32'h000, 32'h0,        1'b1, 2'b00, 1'b1, 32'hA5A5A5A5};
    vecs[7]  = '{1'b1, 1'b0, 32'h400, 32'hBAD0BAD0, 1'b0, 2'b01, 1'b1, 32'hA5A5A5A5};
    vecs[8]  = '{1'b1, 1'b0, 32'h000, 32'hFFFFFFFF, 1'b1, 2'b01, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, 1'b0, 32'h000, 32'h0,        1'b1, 2'b00, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 1'b1, 32'h000, 32'h0,        1'b1, 2'b00, 1'b1, 32'hA5A5A5A5};
    vecs[11] = '{1'b0, 1'b1, 32'h011, 32'h0,        1'b0, 2'b01, 1'b0, 32'h0};
    vecs[12] = '{1'b0, 1'b0, 32'h000, 32'h0,        1'b1, 2'b01, 1'b1, 32'hA5A5A5A5};
    vecs[13] = '{1'b1, 1'b1, 32'h010, 32'h0,        1'b0, 2'b01, 1'b0, 32'h0};
    vecs[14] = '{1'b0, 1'b0, 32'h000, 32'h0,        1'b1, 2'b01, 1'b0, 32'h0};
    vecs[15] = '{1'b0, 1'b1, 32'h010, 32'h0,        1'b1, 2'b00, 1'b1, 32'hDEADBEEF};
    vecs[16] = '{1'b1, 1'b0, 32'h3FC, 32'h0BADF00D, 1'b1, 2'b00, 1'b0, 32'h0};
    vecs[17] = '{1'b0, 1'b1, 32'h3FC, 32'h0,        1'b1, 2'b00, 1'b1, 32'h0BADF00D};

    resetn     = 1'b0;
    addr       = '0;
    write_data = '0;
    write_en   = 1'b0;
    read_en    = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset ready", 32'(rdy0), 32'd1);
    checkOutput("reset resp", 32'(rsp0), 32'd0);
    checkOutput("reset read_data", rd0, 32'h0);
    resetn = 1'b1;

    // Zero-wait table on u0
    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].we, vecs[i].re, vecs[i].a, vecs[i].wd);
      checkOutput($sformatf("vec%0d ready", i), 32'(rdy0), 32'(vecs[i].exp_rdy));
      checkOutput($sformatf("vec%0d resp", i), 32'(rsp0), 32'(vecs[i].exp_rsp));
      if (vecs[i].chk_rd) begin
        checkOutput($sformatf("vec%0d read_data", i), rd0, vecs[i].exp_rd);
      end
    end

    // Asynchronous reset while u0 sits in ERR2 with a non-zero held read_data
    applyStimulus(1'b0, 1'b1, 32'h011, 32'h0);
    checkOutput("pre-reset err1 ready", 32'(rdy0), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("pre-reset err2 resp", 32'(rsp0), 32'd1);
    checkOutput("pre-reset held read_data", rd0, 32'h0BADF00D);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("async reset ready", 32'(rdy0), 32'd1);
    checkOutput("async reset resp", 32'(rsp0), 32'd0);
    checkOutput("async reset read_data", rd0, 32'h0);
    @(negedge clk);
    resetn = 1'b1;

    // Wait-state read on u3/u5 after a write seen by every instance
    applyStimulus(1'b1, 1'b0, 32'h010, 32'hDEADBEEF);
    repeat (8) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    for (int k = 0; k < 7; k++) begin
      if (k == 0) applyStimulus(1'b0, 1'b1, 32'h010, 32'h0);
      else        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      checkOutput($sformatf("ws3 ready c%0d", k), 32'(rdy3), 32'(k >= 3));
      checkOutput($sformatf("ws5 ready c%0d", k), 32'(rdy5), 32'(k >= 5));
      if (k == 0) begin
        checkOutput("ws0 ready c0", 32'(rdy0), 32'd1);
        checkOutput("ws0 read_data c0", rd0, 32'hDEADBEEF);
      end
      if (k == 3) begin
        checkOutput("ws3 resp c3", 32'(rsp3), 32'd0);
        checkOutput("ws3 read_data c3", rd3, 32'hDEADBEEF);
      end
      if (k == 5) checkOutput("ws5 read_data c5", rd5, 32'hDEADBEEF);
    end

    // Error response is two cycles regardless of wait states
    applyStimulus(1'b0, 1'b1, 32'h011, 32'h0);
    checkOutput("ws3 err c0 ready", 32'(rdy3), 32'd0);
    checkOutput("ws3 err c0 resp", 32'(rsp3), 32'd1);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("ws3 err c1 ready", 32'(rdy3), 32'd1);
    checkOutput("ws3 err c1 resp", 32'(rsp3), 32'd1);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("ws3 err c2 ready", 32'(rdy3), 32'd1);
    checkOutput("ws3 err c2 resp", 32'(rsp3), 32'd0);
    checkOutput("ws3 read_data held", rd3, 32'hDEADBEEF);

    // Reset pulled during u5's wait window
    repeat (6) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h010, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("ws5 c2 ready before reset", 32'(rdy5), 32'd0);
    resetn = 1'b0;
    #1;
    checkOutput("ws5 reset ready", 32'(rdy5), 32'd1);
    checkOutput("ws5 reset resp", 32'(rsp5), 32'd0);
    checkOutput("ws5 reset read_data", rd5, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k == 0) applyStimulus(1'b0, 1'b1, 32'h010, 32'h0);
      else        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      if (k == 0) checkOutput("post-reset ws0 read_data", rd0, 32'h0);
      if (k == 4) checkOutput("post-reset ws5 ready c4", 32'(rdy5), 32'd0);
      if (k == 5) begin
        checkOutput("post-reset ws5 ready c5", 32'(rdy5), 32'd1);
        checkOutput("post-reset ws5 read_data", rd5, 32'h0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ahb_sram_slave_core.md
Name: ahb_sram_slave_core

Overview:
Storage endpoint that sits directly downstream of ahb_slave_wrapper and consumes its registered request (addr, write_data, write_en, read_en). It returns read_data, ready and resp. It is a word-addressed register-array memory with a programmable number of wait states and a two-cycle AHB ERROR response for illegal accesses. The wrapper passes ready/resp straight through as Hreadyout/Hresp, so this block owns all data-phase timing.

Parameters:
- DEPTH, 256, number of DATA_WIDTH-bit words; power of two, at least 2.
- BASE_ADDR, 32'h0000_0000, byte address of word 0.
- WAIT_STATES, 0, ready-low cycles inserted before an OKAY completion; range 0..15.
- INIT_ZERO, 1, 1 = array cleared on reset; 0 = array not reset.

Ports:
- clk  input  1  bus clock (Hclk)
- resetn  input  1  asynchronous active-low reset (Hresetn)
- addr  input  ADDR_WIDTH  byte address of request, valid while write_en or read_en is 1
- write_data  input  DATA_WIDTH  write data, valid with write_en
- write_en  input  1  one-cycle write request pulse
- read_en  input  1  one-cycle read request pulse
- read_data  output  DATA_WIDTH  read data, valid in the completion cycle
- ready  output  1  1 = transfer completes this cycle or slave idle
- resp  output  2  2'b00 OKAY, 2'b01 ERROR

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low on resetn.
- Reset values: ready=1, resp=OKAY, read_data=0, state=IDLE, wait counter=0; array cleared when INIT_ZERO=1.
- Request cycle C0 is any cycle with write_en|read_en=1 while state=IDLE. Requests outside IDLE are ignored; the wrapper cannot issue them because Hready is low.
- Error conditions, evaluated in C0:
  - addr<BASE_ADDR, or addr>=BASE_ADDR+DEPTH*DATA_WIDTH/8;
  - addr[log2(DATA_WIDTH/8)-1:0]!=0 (misaligned);
  - write_en and read_en both 1.
- Index = (addr-BASE_ADDR)>>log2(DATA_WIDTH/8).
- FSM states: IDLE, WAIT, ERR1, ERR2; the latched index and direction are held internally.
- IDLE, legal request, WAIT_STATES=0: ready=1 and resp=OKAY in C0. A read drives read_data combinationally from the array in C0. A write commits at the clock edge ending C0. Stay in IDLE, giving back-to-back zero-wait transfers.
- IDLE, legal request, WAIT_STATES=N>0: ready=0 combinationally in C0. Load counter=N-1 and go to WAIT. A write commits at the edge ending C0.
- WAIT: ready=0 while counter!=0; counter decrements each cycle. When counter==0, ready=1, resp=OKAY and read_data=array[latched index], then return to IDLE. Total ready-low cycles = N.
- IDLE, illegal request: ready=0, resp=ERROR in C0 (ERR1 is entered combinationally), then go to ERR2. No array write.
- ERR2: ready=1, resp=ERROR for one cycle, then IDLE. The response is always two cycles regardless of WAIT_STATES.
- read_data outside a read completion cycle holds its last registered value. No X is driven after reset.
- Reads of a word written in the previous transfer return the new data; no hazard exists because the write commits at the end of C0.
- Reset asserted mid-transfer: immediate return to the reset values. A pending write that has already committed is kept; the state is abandoned.
- Arithmetic: index is truncated to log2(DEPTH) bits after the range check. Counter width is 4 bits.

Decomposition:
- Shared package ahb_pkg: resp_e (OKAY=2'b00, ERROR=2'b01), slave_state_e {IDLE, WAIT, ERR1, ERR2}, and the BYTE_LANES=DATA_WIDTH/8 constant. ADDR_WIDTH and DATA_WIDTH stay in parameters.svh.
- One natural sub-module: ahb_sram_array, the register array with a synchronous write port and a combinational read port, parameterised by DEPTH and DATA_WIDTH. FSM, address check and wait counter stay in the top.

Test Plan:
- Reset check: assert resetn=0 mid-simulation -> ready=1, resp=00 and read_data=0 in the same cycle (asynchronous).
- Zero-wait path: WAIT_STATES=0, write addr=0x10 data=0xDEADBEEF, then read 0x10 next cycle -> read cycle has ready=1, resp=00, read_data=0xDEADBEEF, with no ready-low cycles.
- Wait states: WAIT_STATES=3, read 0x10 -> ready low for exactly 3 cycles (C0..C0+2), then ready=1 with read_data=0xDEADBEEF at C0+3.
- Out-of-range: DEPTH=256, write addr=0x400 -> ready=0/resp=01, then ready=1/resp=01, then ready=1/resp=00; a re-read of word 0 shows it is unchanged.
- Misaligned and both-enables: read addr=0x11 and a cycle with write_en=read_en=1 -> each produces the two-cycle ERROR sequence with no array change.
- Reset during WAIT: WAIT_STATES=5, issue read, pull resetn low at C0+2 -> ready=1 immediately. A following read of 0x10 returns 0 when INIT_ZERO=1.
